// File: rtl/cp0_reg_pkg.sv
// cp0_reg shared definitions: register numbers, exception codes,
// ExcCode values, Status/Cause bit positions and reset value.
package cp0_reg_pkg;

  typedef enum logic [4:0] {
    CP0_BADVADDR = 5'd8,
    CP0_COUNT    = 5'd9,
    CP0_COMPARE  = 5'd11,
    CP0_STATUS   = 5'd12,
    CP0_CAUSE    = 5'd13,
    CP0_EPC      = 5'd14
  } cp0_reg_e;

  localparam logic [31:0] ET_NONE = 32'h0;
  localparam logic [31:0] ET_INT  = 32'h1;
  localparam logic [31:0] ET_ADEL = 32'h4;
  localparam logic [31:0] ET_ADES = 32'h5;
  localparam logic [31:0] ET_SYS  = 32'h8;
  localparam logic [31:0] ET_BP   = 32'h9;
  localparam logic [31:0] ET_RI   = 32'ha;
  localparam logic [31:0] ET_OV   = 32'hc;
  localparam logic [31:0] ET_TR   = 32'hd;
  localparam logic [31:0] ET_ERET = 32'he;

  localparam logic [4:0] EXC_INT = 5'd0;

  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 1;
  localparam int ST_BEV     = 22;
  localparam int CA_BD      = 31;
  localparam int CA_IP_HI   = 15;
  localparam int CA_IP_LO   = 10;
  localparam int CA_SW_HI   = 9;
  localparam int CA_SW_LO   = 8;
  localparam int CA_EXC_HI  = 6;
  localparam int CA_EXC_LO  = 2;

  localparam logic [31:0] ST_WMASK       = 32'h0000_FF03;
  localparam logic [31:0] ST_BEV_MASK    = 32'h0040_0000;
  localparam logic [31:0] CP0_STATUS_RST = 32'h0040_0000;

  typedef struct packed {
    logic       take;
    logic       eret;
    logic       ld_bad;
    logic [4:0] exccode;
  } exc_dec_t;

  function automatic exc_dec_t exc_decode(
    input logic [31:0] et
  );
    exc_dec_t d;
    d = '0;
    unique case (1'b1)
      (et == ET_INT): begin
        d.take    = 1'b1;
        d.exccode = EXC_INT;
      end
      (et == ET_ADEL),
      (et == ET_ADES): begin
        d.take    = 1'b1;
        d.ld_bad  = 1'b1;
        d.exccode = et[4:0];
      end
      (et == ET_SYS),
      (et == ET_BP),
      (et == ET_RI),
      (et == ET_OV),
      (et == ET_TR): begin
        d.take    = 1'b1;
        d.exccode = et[4:0];
      end
      (et == ET_ERET): begin
        d.eret = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// cp0_reg mtc0 write bus.
// Carries the WB-stage write enable, register number and data.
interface cp0_reg_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport master (
    output we,
    output waddr,
    output wdata
  );

  modport slave (
    input we,
    input waddr,
    input wdata
  );
endinterface

// File: rtl/cp0_timer.sv
// cp0_reg timer: prescaler, Count, Compare, timer interrupt.
// Compare match logic exists only with CP0_TIMER_INT_EN defined.
module cp0_timer
  import cp0_reg_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  cp0_reg_if.slave    wr,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_timer_int
);

  localparam int PW =
    (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] r_pre;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          w_tick;
  logic          w_wr_count;
  logic          w_wr_cmp;

  assign w_tick     = (r_pre == PW'(COUNT_DIV - 1));
  assign w_wr_count = wr.we && (wr.waddr == CP0_COUNT);
  assign w_wr_cmp   = wr.we && (wr.waddr == CP0_COMPARE);

  // prescaler and Count; a Count write restarts the prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre   <= '0;
      r_count <= '0;
    end else if (w_wr_count) begin
      r_pre   <= '0;
      r_count <= wr.wdata;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_count <= r_count + 32'd1;
    end
  end

  // Compare register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_compare <= '0;
    else if (w_wr_cmp) r_compare <= wr.wdata;
  end

`ifdef CP0_TIMER_INT_EN
  logic r_tint;

  // sticky match flag; a Compare write wins over a new match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tint <= 1'b0;
    else if (w_wr_cmp) r_tint <= 1'b0;
    else if ((r_compare != '0) &&
             (r_count == r_compare))
      r_tint <= 1'b1;
  end

  assign o_timer_int = r_tint;
`else
  assign o_timer_int = 1'b0;
`endif

  assign o_count   = r_count;
  assign o_compare = r_compare;

endmodule

// File: rtl/cp0_reg.sv
// cp0_reg: CP0 register file (Status/Cause/EPC/BadVAddr + timer).
// Optional macro CP0_TIMER_INT_EN enables the Count/Compare interrupt.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = CP0_STATUS_RST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] data_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  cp0_reg_if u_wr_if ();

  assign u_wr_if.we    = we_i;
  assign u_wr_if.waddr = waddr_i;
  assign u_wr_if.wdata = data_i;

  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic [31:0] w_status_n;
  logic [31:0] w_cause_n;
  logic [31:0] w_epc_n;
  logic [31:0] w_bad_n;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_tint;
  exc_dec_t    w_exc;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .wr          (u_wr_if.slave),
    .o_count     (w_count),
    .o_compare   (w_compare),
    .o_timer_int (w_tint)
  );

  assign w_exc = exc_decode(excepttype_i);

  // next state: mtc0 first, exception applied on top
  always_comb begin
    w_status_n = r_status;
    w_cause_n  = r_cause;
    w_epc_n    = r_epc;
    w_bad_n    = r_badvaddr;

    w_cause_n[CA_IP_HI:CA_IP_LO] =
      {int_i[5] | w_tint, int_i[4:0]};

    if (we_i) begin
      unique case (waddr_i)
        CP0_BADVADDR: w_bad_n = data_i;
        CP0_STATUS:
          w_status_n = (data_i & ST_WMASK) |
                       ST_BEV_MASK;
        CP0_CAUSE:
          w_cause_n[CA_SW_HI:CA_SW_LO] =
            data_i[CA_SW_HI:CA_SW_LO];
        CP0_EPC:      w_epc_n = data_i;
        default: ;
      endcase
    end

    if (w_exc.take) begin
      if (!w_status_n[ST_EXL]) begin
        w_epc_n = is_in_delayslot_i ?
          current_inst_addr_i - 32'd4 :
          current_inst_addr_i;
        w_cause_n[CA_BD] = is_in_delayslot_i;
      end
      w_status_n[ST_EXL] = 1'b1;
      w_cause_n[CA_EXC_HI:CA_EXC_LO] =
        w_exc.exccode;
      if (w_exc.ld_bad) w_bad_n = bad_addr_i;
    end else if (w_exc.eret) begin
      w_status_n[ST_EXL] = 1'b0;
    end
  end

  // architectural register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status   <= STATUS_RST;
      r_cause    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      r_status   <= w_status_n;
      r_cause    <= w_cause_n;
      r_epc      <= w_epc_n;
      r_badvaddr <= w_bad_n;
    end
  end

  // mfc0 read mux; unmapped numbers read zero
  always_comb begin
    data_o = '0;
    unique case (raddr_i)
      CP0_BADVADDR: data_o = r_badvaddr;
      CP0_COUNT:    data_o = w_count;
      CP0_COMPARE:  data_o = w_compare;
      CP0_STATUS:   data_o = r_status;
      CP0_CAUSE:    data_o = r_cause;
      CP0_EPC:      data_o = r_epc;
      default: ;
    endcase
  end

  assign count_o     = w_count;
  assign compare_o   = w_compare;
  assign status_o    = r_status;
  assign cause_o     = r_cause;
  assign epc_o       = r_epc;
  assign badvaddr_o  = r_badvaddr;
  assign timer_int_o = w_tint;

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed + random checks of cp0_reg
// against an in-bench behavioural model.
module tb_cp0_reg;

  localparam int DIV = 2;
`ifdef CP0_TIMER_INT_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  raddr = '0;
  logic [5:0]  int_i = '0;
  logic [31:0] et = '0;
  logic [31:0] pc = '0;
  logic        ds = 1'b0;
  logic [31:0] bad = '0;
  logic [31:0] data_o, count_o, compare_o;
  logic [31:0] status_o, cause_o, epc_o;
  logic [31:0] badvaddr_o;
  logic        timer_int_o;

  cp0_reg_if bus ();

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  cp0_reg #(.COUNT_DIV(DIV)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (bus.we),
    .waddr_i             (bus.waddr),
    .data_i              (bus.wdata),
    .raddr_i             (raddr),
    .data_o              (data_o),
    .int_i               (int_i),
    .excepttype_i        (et),
    .current_inst_addr_i (pc),
    .is_in_delayslot_i   (ds),
    .bad_addr_i          (bad),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .badvaddr_o          (badvaddr_o),
    .timer_int_o         (timer_int_o)
  );

  // behavioural model
  logic [31:0] m_status = 32'h0040_0000;
  logic [31:0] m_cause  = '0;
  logic [31:0] m_epc    = '0;
  logic [31:0] m_bad    = '0;
  logic [31:0] m_cmp    = '0;
  logic [31:0] m_cbase  = '0;
  int unsigned m_since  = 0;
  logic        m_tint   = 1'b0;

  function automatic logic [31:0] m_count();
    return m_cbase + 32'(m_since / DIV);
  endfunction

  function automatic logic [31:0] m_read(
    input logic [4:0] a
  );
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count();
      5'd11:   return m_cmp;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_exc(
    input logic [31:0] c
  );
    return c == 1 || c == 4 || c == 5 ||
           c == 8 || c == 9 || c == 10 ||
           c == 12 || c == 13;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [31:0] st, ca, ep, bv, cnt;
    logic        tn;
    bit          cw;
    if (!rst) begin
      m_status = 32'h0040_0000;
      m_cause  = '0;
      m_epc    = '0;
      m_bad    = '0;
      m_cmp    = '0;
      m_cbase  = '0;
      m_since  = 0;
      m_tint   = 1'b0;
    end else begin
      cnt = m_count();
      tn  = m_tint | (TIMER_EN && m_cmp != 0
                      && cnt == m_cmp);
      st = m_status; ca = m_cause;
      ep = m_epc;    bv = m_bad;
      cw = 1'b0;
      if (bus.we) begin
        case (bus.waddr)
          5'd8:  bv = bus.wdata;
          5'd9:  begin
            m_cbase = bus.wdata;
            m_since = 0;
            cw = 1'b1;
          end
          5'd11: begin
            m_cmp = bus.wdata;
            tn = 1'b0;
          end
          5'd12: st = (bus.wdata & 32'h0000_FF03)
                      | 32'h0040_0000;
          5'd13: ca[9:8] = bus.wdata[9:8];
          5'd14: ep = bus.wdata;
          default: ;
        endcase
      end
      if (!cw) m_since++;
      ca[15:10] = {int_i[5] | m_tint, int_i[4:0]};
      if (is_exc(et)) begin
        if (!st[1]) begin
          ep = ds ? pc - 4 : pc;
          ca[31] = ds;
        end
        st[1] = 1'b1;
        ca[6:2] = (et == 1) ? 5'd0 : et[4:0];
        if (et == 4 || et == 5) bv = bad;
      end else if (et == 32'he) begin
        st[1] = 1'b0;
      end
      m_status = st; m_cause = ca;
      m_epc = ep;    m_bad = bv;
      m_tint = tn;
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] a,
    input logic [31:0] e
  );
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, a, e);
    end
  endtask

  // per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("count", count_o, m_count());
      chk("compare", compare_o, m_cmp);
      chk("status", status_o, m_status);
      chk("cause", cause_o, m_cause);
      chk("epc", epc_o, m_epc);
      chk("badvaddr", badvaddr_o, m_bad);
      chk("timer_int", 32'(timer_int_o),
          32'(m_tint));
      chk("data_o", data_o, m_read(raddr));
    end
  end

  task automatic mtc0(
    input logic [4:0]  a,
    input logic [31:0] d
  );
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic exc(
    input logic [31:0] c,
    input logic [31:0] p,
    input logic        d,
    input logic [31:0] b
  );
    et = c; pc = p; ds = d; bad = b;
    @(negedge clk);
    et = '0; ds = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  logic [4:0] wa [9] = '{5'd8, 5'd9, 5'd11,
    5'd12, 5'd13, 5'd14, 5'd0, 5'd3, 5'd15};
  logic [31:0] ec [12] = '{32'h1, 32'h4, 32'h5,
    32'h8, 32'h9, 32'ha, 32'hc, 32'hd, 32'he,
    32'he, 32'h7, 32'h0};

  initial begin
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_count", count_o, 32'h0);
    chk("rst_tint", 32'(timer_int_o), 32'h0);
    repeat (9) @(negedge clk);
    chk("count_after10", count_o, 32'd5);

    exc(32'h7, 32'h1234, 1'b0, 32'h0);
    chk("unk_status", status_o, 32'h0040_0000);
    chk("unk_epc", epc_o, 32'h0);

    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd3);
    for (int i = 0; i < 50 && count_o != 3; i++)
      @(negedge clk);
    chk("timer_wait", count_o, 32'd3);
    @(negedge clk);
    chk("timer_set", 32'(timer_int_o),
        32'(TIMER_EN));
    @(negedge clk);
    chk("cause_ip7", 32'(cause_o[15]),
        32'(TIMER_EN));
    mtc0(5'd11, 32'd100);
    chk("timer_clr", 32'(timer_int_o), 32'h0);

    exc(32'h8, 32'hBFC0_0104, 1'b1, 32'h0);
    chk("sys_epc", epc_o, 32'hBFC0_0100);
    chk("sys_bd", 32'(cause_o[31]), 32'h1);
    chk("sys_code", 32'(cause_o[6:2]), 32'd8);
    chk("sys_exl", 32'(status_o[1]), 32'h1);

    exc(32'h4, 32'h0000_1234, 1'b0, 32'h3);
    chk("adel_bad", badvaddr_o, 32'h3);
    chk("adel_code", 32'(cause_o[6:2]), 32'd4);
    chk("adel_epc", epc_o, 32'hBFC0_0100);

    bus.we = 1'b1; bus.waddr = 5'd14;
    bus.wdata = 32'h8000_0000;
    exc(32'he, 32'h0, 1'b0, 32'h0);
    bus.we = 1'b0;
    chk("eret_exl", 32'(status_o[1]), 32'h0);
    chk("eret_epc", epc_o, 32'h8000_0000);

    mtc0(5'd9, 32'hFFFF_FFFF);
    chk("cnt_load", count_o, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    chk("cnt_wrap", count_o, 32'h0);

    mtc0(5'd12, 32'h0);
    chk("st_bev", status_o, 32'h0040_0000);
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk("st_mask", status_o, 32'h0040_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("ca_ip_ro", 32'(cause_o[15:10]), 32'h0);
    chk("ca_sw", 32'(cause_o[9:8]), 32'h3);
    int_i = 6'b101010;
    @(negedge clk);
    chk("ca_hwint", 32'(cause_o[15:10]), 32'h2A);
    int_i = '0;

    raddr = 5'd12; #1;
    chk("rd_status", data_o, 32'h0040_FF03);
    raddr = 5'd3; #1;
    chk("rd_unmapped", data_o, 32'h0);
    raddr = 5'd8; #1;
    chk("rd_bad", data_o, 32'h3);

    #2 rst = 1'b0;
    #1;
    chk("arst_status", status_o, 32'h0040_0000);
    chk("arst_count", count_o, 32'h0);
    chk("arst_epc", epc_o, 32'h0);
    chk("arst_bad", badvaddr_o, 32'h0);
    chk("arst_cause", cause_o, 32'h0);
    #1 rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2000; i++) begin
      bus.we = ($urandom_range(0, 9) < 3);
      bus.waddr = wa[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
        0: bus.wdata = m_count() +
                       32'($urandom_range(1, 8));
        1: bus.wdata = 32'hFFFF_FFF0 +
                       32'($urandom_range(0, 15));
        default: bus.wdata = $urandom;
      endcase
      int_i = 6'($urandom);
      raddr = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 19) < 12) et = '0;
      else if ($urandom_range(0, 15) == 0)
        et = $urandom;
      else et = ec[$urandom_range(0, 11)];
      pc  = $urandom;
      ds  = 1'($urandom);
      bad = $urandom;
      @(negedge clk);
    end
    bus.we = 1'b0; et = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
